// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine that also owns the HI/LO registers.
// Latency: WIDTH+2 cycles from the start edge to the done pulse (2 cycles for a skipped divide-by-zero).
// Backpressure: none queued; start is honoured only while idle, otherwise dropped (busy tells the caller).
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   start, op, a, b        launch request, opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), operands
//   hi_wr, lo_wr, wdata    MTHI/MTLO writes, honoured only while idle and not starting
//   busy, done, div_zero   in-progress flag, one-cycle completion pulse, divide-by-zero pulse
//   hi, lo                 architectural HI/LO (product high/low, remainder/quotient)
//
// Optional feature: define MULT_DIV_DIVZERO_EN to short-circuit DIV/DIVU by zero straight to FIX,
// leaving hi/lo untouched and pulsing div_zero with done. Without it div_zero is tied low and a
// divide by zero runs the full iteration count.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // mult: {partial hi, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    // Operand decode and magnitudes (unsigned ops never count as negative)
    logic                 in_signed, in_div, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;

    assign in_signed = ~op[0];
    assign in_div    = op[1];
    assign a_neg     = in_signed & a[WIDTH-1];
    assign b_neg     = in_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? (~a + 1'b1) : a;
    assign b_mag     = b_neg ? (~b + 1'b1) : b;

    // One shift-add multiply step: add multiplicand to the upper half when the
    // current multiplier LSB is set, then shift the whole accumulator right.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring divide step: shift the next dividend bit into the remainder,
    // trial-subtract the divisor, keep the difference only if it did not go negative.
    // With a zero divisor every trial succeeds, so the quotient fills with ones and the
    // remainder ends up holding the dividend magnitude.
    logic [WIDTH:0]       div_shift, div_diff;
    logic [2*WIDTH-1:0]   div_next;

    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    // Sign fix-up applied in FIX
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_raw, rem_raw, quo_fix, rem_fix;

    assign quo_raw  = acc_q[WIDTH-1:0];
    assign rem_raw  = acc_q[2*WIDTH-1:WIDTH];
    assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix  = neg_res_q ? (~quo_raw + 1'b1) : quo_raw;
    assign rem_fix  = neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;

`ifdef MULT_DIV_DIVZERO_EN
    logic skip_q, skip_d;
    logic dz_q, dz_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MULT_DIV_DIVZERO_EN
        skip_d    = skip_q;
        dz_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // start beats a simultaneous MTHI/MTLO; the write is dropped
                    cnt_d     = CW'(WIDTH);
                    acc_d     = in_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                    opnd_d    = in_div ? b_mag : a_mag;
                    is_div_d  = in_div;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    state_d   = S_RUN;
`ifdef MULT_DIV_DIVZERO_EN
                    skip_d    = in_div && (b == '0);
                    if (in_div && (b == '0)) begin
                        state_d = S_FIX;
                    end
`endif
                end else begin
                    if (hi_wr) hi_d = wdata;
                    if (lo_wr) lo_d = wdata;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
`ifdef MULT_DIV_DIVZERO_EN
                if (skip_q) begin
                    dz_d = 1'b1;
                end else
`endif
                if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MULT_DIV_DIVZERO_EN
            skip_q    <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MULT_DIV_DIVZERO_EN
            skip_q    <= skip_d;
            dz_q      <= dz_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN) || (state_q == S_FIX);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULT_DIV_DIVZERO_EN
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit, checked every cycle against a
// cycle-count/arithmetic model, plus literal expectations for the documented vectors.
// Timing: inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_mult_div_unit;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset, start, hi_wr, lo_wr;
    logic [1:0]    op;
    logic [W-1:0]  a, b, wdata;
    logic          busy, done, div_zero;
    logic [W-1:0]  hi, lo;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int lat, bc, dn;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} from plain arithmetic
    function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, sy;
        longint      q, r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            2'b00: return sx * sy;
            2'b01: return {32'b0, x} * {32'b0, y};
            2'b10: begin
                if (y == 0) return {x, (x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
                q = $signed(sx) / $signed(sy);
                r = $signed(sx) % $signed(sy);
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Model: remaining busy cycles plus the pending result
    int           m_left = 0;
    logic [31:0]  m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic         m_done = 1'b0, m_dz = 1'b0;
    bit           m_skip = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0;
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    if (m_skip) m_dz = 1'b1;
                    else {m_hi, m_lo} = {p_hi, p_lo};
                end
            end else if (start) begin
                {p_hi, p_lo} = model_res(op, a, b);
                m_skip = 1'b0;
`ifdef MULT_DIV_DIVZERO_EN
                if (op[1] && b == 0) m_skip = 1'b1;
`endif
                m_left = m_skip ? 1 : W + 1;
            end else begin
                if (hi_wr) m_hi = wdata;
                if (lo_wr) m_lo = wdata;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
            check("cyc_done", {31'b0, done}, {31'b0, m_done});
            check("cyc_div_zero", {31'b0, div_zero}, {31'b0, m_dz});
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    // Issue one op and wait (bounded) for done; operands/op are scrambled after the start cycle
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int l, output int bcount);
        op = o; a = x; b = y; start = 1'b1;
        l = 0; bcount = 0;
        forever begin
            @(negedge clock);
            l++;
            if (l == 1) begin
                start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
                op = ~o; a = $urandom; b = $urandom;
            end
            if (busy === 1'b1) bcount++;
            if (done === 1'b1) break;
            if (l >= 100) begin
                n_cmp++; n_bad++;
                $display("FAIL done_timeout: no done after %0d cycles, expected within 100", l);
                break;
            end
        end
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clock);
            if (done === 1'b1) break;
        end
        if (k == 100) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_done_timeout: no done in %0d cycles, expected within 100", k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_div_zero", {31'b0, div_zero}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, lat, bc);
        check("mult_latency", lat, 34);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        // back-to-back: issued in the done cycle
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        check("multu_busy_cycles", bc, 33);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, bc);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(2'b11, 32'd7, 32'd2, lat, bc);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0);

        run_op(2'b11, 32'd7, 32'd2, lat, bc);
        run_op(2'b11, 32'h1234_5678, 32'h0, lat, bc);
`ifdef MULT_DIV_DIVZERO_EN
        check("divz_latency", lat, 2);
        check("divz_flag", {31'b0, div_zero}, 32'h1);
        check("divz_hi_kept", hi, 32'd1);
        check("divz_lo_kept", lo, 32'd3);
`else
        check("divz_latency", lat, 34);
        check("divz_flag", {31'b0, div_zero}, 32'h0);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'h1234_5678);
`endif

        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, bc);
        check("mult_minmin_hi", hi, 32'h4000_0000);
        check("mult_minmin_lo", lo, 32'h0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0, lat, bc);
        run_op(2'b01, 32'h0, 32'h1234_5678, lat, bc);
        check("multu_zero_lo", lo, 32'h0);
        repeat (2) @(negedge clock);

        // Reset in RUN cycle 10 aborts with no done
        op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        dn = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) dn++;
        end
        check("abort_no_done", dn, 0);
        run_op(2'b00, 32'd5, 32'd6, lat, bc);
        check("after_abort_lo", lo, 32'd30);
        check("after_abort_hi", hi, 32'd0);
        repeat (2) @(negedge clock);

        // start and MTHI while busy are ignored
        op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7; hi_wr = 1'b1; wdata = 32'hAAAA_5555;
        @(negedge clock);
        start = 1'b0; hi_wr = 1'b0;
        wait_done();
        check("busy_ign_hi", hi, 32'h0);
        check("busy_ign_lo", lo, 32'd12);
        @(negedge clock);
        check("busy_ign_no_restart", {31'b0, busy}, 32'h0);

        // MTLO / MTHI+MTLO in IDLE
        lo_wr = 1'b1; wdata = 32'h0000_BEEF;
        @(negedge clock);
        lo_wr = 1'b0;
        check("mtlo_lo", lo, 32'h0000_BEEF);
        check("mtlo_hi", hi, 32'h0);
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clock);
        hi_wr = 1'b0; lo_wr = 1'b0;
        check("mtboth_hi", hi, 32'hCAFE_F00D);
        check("mtboth_lo", lo, 32'hCAFE_F00D);

        // start wins over a simultaneous MTHI
        hi_wr = 1'b1; wdata = 32'h1111_1111;
        run_op(2'b11, 32'd20, 32'd6, lat, bc);
        check("start_wins_lo", lo, 32'd3);
        check("start_wins_hi", hi, 32'd2);

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
